// File: rtl/memory_pkg.sv
// Shared types and byte-lane helpers for unified_memory: access-mode and FSM
// enums, store lane masks, load extraction and the LWL/LWR merge functions.
package memory_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BYTE     = 2'd1,
        HALFWORD = 2'd2,
        WORD     = 2'd3
    } readWriteModes;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_e;

    function automatic logic [3:0] store_lane_mask(input readWriteModes mode, input logic [1:0] k);
        case (mode)
            BYTE:     return 4'b0001 << k;
            HALFWORD: return 4'b0011 << k;
            WORD:     return 4'b1111;
            default:  return 4'b0000;
        endcase
    endfunction

    // Replicate the store data so every candidate lane sees its own bytes.
    function automatic logic [31:0] store_lane_data(input readWriteModes mode, input logic [31:0] d);
        case (mode)
            BYTE:     return {4{d[7:0]}};
            HALFWORD: return {2{d[15:0]}};
            default:  return d;
        endcase
    endfunction

    // 3-k equals ~k on two bits, so SWL writes lanes 0..k.
    function automatic logic [3:0] swl_mask(input logic [1:0] k);
        return 4'b1111 >> (~k);
    endfunction

    function automatic logic [3:0] swr_mask(input logic [1:0] k);
        return 4'b1111 << k;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input readWriteModes mode,
                                                  input logic [1:0] k, input logic sgn);
        logic [31:0] w;
        w = word >> {k, 3'b000};
        case (mode)
            BYTE:     return sgn ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
            HALFWORD: return sgn ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            WORD:     return word;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] lwl_merge(input logic [31:0] mem, input logic [31:0] old,
                                               input logic [1:0] k);
        logic [4:0] sh;
        sh = {~k, 3'b000};
        return (mem << sh) | (old & ~(32'hFFFF_FFFF << sh));
    endfunction

    function automatic logic [31:0] lwr_merge(input logic [31:0] mem, input logic [31:0] old,
                                               input logic [1:0] k);
        logic [4:0] sh;
        sh = {k, 3'b000};
        return (mem >> sh) | (old & ~(32'hFFFF_FFFF >> sh));
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit lane of unified_memory: a single write port and two registered,
// read-first read ports with individual enables so their outputs can hold.
module byte_lane_ram #(
    parameter int WORDS = 16,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re_a,
    input  logic [IW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic          re_b,
    input  logic [IW-1:0] raddr_b,
    output logic [7:0]    rdata_b
);

    logic [7:0] mem_q [WORDS];
    logic [7:0] rdata_a_q;
    logic [7:0] rdata_b_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Reads sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_a_q <= 8'd0;
            rdata_b_q <= 8'd0;
        end else begin
            if (re_a) begin
                rdata_a_q <= mem_q[raddr_a];
            end
            if (re_b) begin
                rdata_b_q <= mem_q[raddr_b];
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/unified_memory.sv
// Byte-addressable four-lane memory with a data port and a fetch port, zero-filled
// after reset. Macro UNALIGNED_EN enables the LWL/LWR/SWL/SWR merge paths.
module unified_memory
    import memory_pkg::*;
#(
    parameter int DEPTH_BYTES = 65536,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data,
    input  logic [1:0]        writeMode,
    input  logic [1:0]        readMode,
    input  logic              signedRead,
    input  logic              unalignedLeft,
    input  logic              unalignedRight,
    input  logic [ADDR_W-1:0] pcAddress,
    input  logic              faultClear,
    output logic              ready,
    output logic [31:0]       dataOutput,
    output logic              dataValid,
    output logic [31:0]       pcDataOutput,
    output logic              pcValid,
    output logic              fault,
    output logic [ADDR_W-1:0] faultAddress
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int IW    = $clog2(WORDS);
`ifdef UNALIGNED_EN
    localparam logic UNALIGNED_SUPPORTED = 1'b1;
`else
    localparam logic UNALIGNED_SUPPORTED = 1'b0;
`endif

    // Handshake: ready is high only in RUN; every RUN cycle with a mode set is a
    // request and is always accepted (no backpressure). dataValid is a one-cycle
    // response pulse one edge later; pcValid stays high while fetch data is valid.

    mem_state_e    state_q, state_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == IW'(WORDS - 1)) begin
                state_d    = RUN;
                init_cnt_d = '0;
            end
        end
    end

    logic          is_run;
    readWriteModes rd_mode, wr_mode, op_mode;
    logic [1:0]    lane_k;
    logic          any_flag;
    logic          is_req;
    logic          illegal;
    logic          ld_ok;
    logic          st_ok;
    logic [IW-1:0] addr_word;
    logic [IW-1:0] pc_word;
    logic          unused_addr;

    assign is_run    = (state_q == RUN);
    assign ready     = is_run;
    assign rd_mode   = readWriteModes'(readMode);
    assign wr_mode   = readWriteModes'(writeMode);
    assign op_mode   = (rd_mode != NONE) ? rd_mode : wr_mode;
    assign lane_k    = address[1:0];
    assign any_flag  = unalignedLeft | unalignedRight;
    assign addr_word = address[IW+1:2];
    assign pc_word   = pcAddress[IW+1:2];
    // High address bits wrap and the low fetch bits are don't-care.
    assign unused_addr = ^{address, pcAddress};

    assign is_req  = is_run && ((rd_mode != NONE) || (wr_mode != NONE));
    assign illegal = is_req && (((rd_mode != NONE) && (wr_mode != NONE)) ||
                                (unalignedLeft && unalignedRight) ||
                                (any_flag && (op_mode != WORD)) ||
                                (any_flag && !UNALIGNED_SUPPORTED) ||
                                ((op_mode == HALFWORD) && lane_k[0]) ||
                                ((op_mode == WORD) && !any_flag && (lane_k != 2'b00)));
    assign ld_ok   = is_req && !illegal && (rd_mode != NONE);
    assign st_ok   = is_req && !illegal && (wr_mode != NONE);

    logic [3:0]    wr_mask;
    logic [31:0]   wr_word;
    logic [IW-1:0] wr_addr;

    always_comb begin
        wr_mask = 4'b0000;
        wr_word = 32'd0;
        wr_addr = addr_word;
        if (state_q == INIT) begin
            wr_mask = 4'b1111;
            wr_addr = init_cnt_q;
        end else if (st_ok) begin
`ifdef UNALIGNED_EN
            if (unalignedLeft) begin
                wr_mask = swl_mask(lane_k);
                wr_word = data >> {~lane_k, 3'b000};
            end else if (unalignedRight) begin
                wr_mask = swr_mask(lane_k);
                wr_word = data << {lane_k, 3'b000};
            end else begin
                wr_mask = store_lane_mask(wr_mode, lane_k);
                wr_word = store_lane_data(wr_mode, data);
            end
`else
            wr_mask = store_lane_mask(wr_mode, lane_k);
            wr_word = store_lane_data(wr_mode, data);
`endif
        end
    end

    logic [31:0] ld_word;
    logic [31:0] pc_word_rd;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        byte_lane_ram #(.WORDS(WORDS), .IW(IW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (wr_mask[g]),
            .waddr   (wr_addr),
            .wdata   (wr_word[8*g +: 8]),
            .re_a    (ld_ok),
            .raddr_a (addr_word),
            .rdata_a (ld_word[8*g +: 8]),
            .re_b    (is_run),
            .raddr_b (pc_word),
            .rdata_b (pc_word_rd[8*g +: 8])
        );
    end

    // Load context is captured only on loads so dataOutput holds between them.
    readWriteModes ld_mode_q;
    logic [1:0]    ld_k_q;
    logic          ld_signed_q;
    logic          data_valid_q;
    logic          pc_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_mode_q    <= NONE;
            ld_k_q       <= 2'b00;
            ld_signed_q  <= 1'b0;
            data_valid_q <= 1'b0;
            pc_valid_q   <= 1'b0;
        end else begin
            data_valid_q <= ld_ok | illegal;
            pc_valid_q   <= is_run;
            if (ld_ok) begin
                ld_mode_q   <= rd_mode;
                ld_k_q      <= lane_k;
                ld_signed_q <= signedRead;
            end else if (illegal) begin
                ld_mode_q <= NONE;
            end
        end
    end

`ifdef UNALIGNED_EN
    logic        ld_left_q;
    logic        ld_right_q;
    logic [31:0] ld_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_left_q  <= 1'b0;
            ld_right_q <= 1'b0;
            ld_data_q  <= 32'd0;
        end else if (ld_ok) begin
            ld_left_q  <= unalignedLeft;
            ld_right_q <= unalignedRight;
            ld_data_q  <= data;
        end
    end
`endif

    always_comb begin
        dataOutput = load_extract(ld_word, ld_mode_q, ld_k_q, ld_signed_q);
`ifdef UNALIGNED_EN
        if ((ld_mode_q == WORD) && ld_left_q) begin
            dataOutput = lwl_merge(ld_word, ld_data_q, ld_k_q);
        end else if ((ld_mode_q == WORD) && ld_right_q) begin
            dataOutput = lwr_merge(ld_word, ld_data_q, ld_k_q);
        end
`endif
    end

    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    // A clear and a new fault in the same cycle leave the new fault recorded.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (is_run && faultClear) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
        end
        if (illegal) begin
            fault_d = 1'b1;
            if (!fault_q || faultClear) begin
                fault_addr_d = address;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign dataValid    = data_valid_q;
    assign pcDataOutput = pc_word_rd;
    assign pcValid      = pc_valid_q;
    assign fault        = fault_q;
    assign faultAddress = fault_addr_q;

endmodule

// File: tb/tb_unified_memory.sv
// Directed bench for unified_memory (64-byte instance): stimulus tasks push expected
// responses into queues, a negedge monitor pops and compares them.
module tb_unified_memory;

  localparam int DEPTH = 64;
  localparam int AW = 32;
  localparam logic [1:0] M_NONE = 2'd0;
  localparam logic [1:0] M_BYTE = 2'd1;
  localparam logic [1:0] M_HALF = 2'd2;
  localparam logic [1:0] M_WORD = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] address = '0;
  logic [31:0] data = '0;
  logic [1:0] writeMode = '0;
  logic [1:0] readMode = '0;
  logic signedRead = 1'b0;
  logic unalignedLeft = 1'b0;
  logic unalignedRight = 1'b0;
  logic [AW-1:0] pcAddress = '0;
  logic faultClear = 1'b0;
  logic ready;
  logic [31:0] dataOutput;
  logic dataValid;
  logic [31:0] pcDataOutput;
  logic pcValid;
  logic fault;
  logic [AW-1:0] faultAddress;

  unified_memory #(.DEPTH_BYTES(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .address(address), .data(data),
    .writeMode(writeMode), .readMode(readMode), .signedRead(signedRead),
    .unalignedLeft(unalignedLeft), .unalignedRight(unalignedRight),
    .pcAddress(pcAddress), .faultClear(faultClear), .ready(ready),
    .dataOutput(dataOutput), .dataValid(dataValid), .pcDataOutput(pcDataOutput),
    .pcValid(pcValid), .fault(fault), .faultAddress(faultAddress)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  string name_q[$];
  logic [32:0] pc_exp_q[$];
  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b1;
  logic [31:0] mon_e;
  string mon_n;
  logic [32:0] mon_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dataValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dataValid: got pulse with dataOutput %h, expected no response", dataOutput);
        end else begin
          mon_e = exp_q.pop_front();
          mon_n = name_q.pop_front();
          chk(mon_n, dataOutput, mon_e);
        end
      end
      if (pcValid) begin
        if (pc_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pcValid: got pcValid=1, expected 0");
        end else begin
          mon_pc = pc_exp_q.pop_front();
          if (mon_pc[32]) chk("fetch", pcDataOutput, mon_pc[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] rm, input logic [1:0] wm, input logic [31:0] a,
                       input logic [31:0] d, input logic sg, input logic ul, input logic ur,
                       input logic clr, input logic [31:0] pc, input logic exp_v,
                       input logic [31:0] exp_d, input string nm, input logic pc_chk,
                       input logic [31:0] pc_e);
    readMode = rm;
    writeMode = wm;
    address = a;
    data = d;
    signedRead = sg;
    unalignedLeft = ul;
    unalignedRight = ur;
    faultClear = clr;
    pcAddress = pc;
    if (exp_v) begin
      exp_q.push_back(exp_d);
      name_q.push_back(nm);
    end
    pc_exp_q.push_back({pc_chk, pc_e});
    @(posedge clk);
    #1;
    readMode = M_NONE;
    writeMode = M_NONE;
    signedRead = 1'b0;
    unalignedLeft = 1'b0;
    unalignedRight = 1'b0;
    faultClear = 1'b0;
  endtask

  task automatic do_load(input string nm, input logic [1:0] m, input logic [31:0] a,
                         input logic sg, input logic ul, input logic ur,
                         input logic [31:0] d, input logic [31:0] e);
    issue(m, M_NONE, a, d, sg, ul, ur, 1'b0, 32'h0, 1'b1, e, nm, 1'b0, 32'h0);
  endtask

  task automatic do_store(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d,
                          input logic ul, input logic ur);
    issue(M_NONE, m, a, d, 1'b0, ul, ur, 1'b0, 32'h0, 1'b0, 32'h0, "", 1'b0, 32'h0);
  endtask

  task automatic do_bad(input string nm, input logic [1:0] rm, input logic [1:0] wm,
                        input logic [31:0] a, input logic ul, input logic ur, input logic clr);
    issue(rm, wm, a, 32'hFFFF_FFFF, 1'b0, ul, ur, clr, 32'h0, 1'b1, 32'h0, nm, 1'b0, 32'h0);
  endtask

  task automatic do_idle(input logic clr, input logic [31:0] pc, input logic pc_chk,
                         input logic [31:0] pc_e);
    issue(M_NONE, M_NONE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, clr, pc, 1'b0, 32'h0, "", pc_chk, pc_e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int init_cycles;
    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_dataValid", {31'd0, dataValid}, 32'd0);
    chk("rst_pcValid", {31'd0, pcValid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_dataOutput", dataOutput, 32'd0);
    chk("rst_pcDataOutput", pcDataOutput, 32'd0);
    chk("rst_faultAddress", faultAddress, 32'd0);

    // partial INIT, then reset again
    rst = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("ready_mid_init", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    init_cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        init_cycles = i;
        break;
      end
    end
    chk("init_cycles", 32'(init_cycles), 32'd16);

    // zero-filled memory
    issue(M_WORD, M_NONE, 32'h3C, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3C, 1'b1, 32'h0,
          "lw_3c_zero", 1'b1, 32'h0);

    // byte store, signed/unsigned byte and word loads
    do_store(M_BYTE, 32'h5, 32'h0000_0080, 1'b0, 1'b0);
    do_load("lb_5", M_BYTE, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FF80);
    do_load("lbu_5", M_BYTE, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0080);
    do_load("lw_4", M_WORD, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_8000);

    // store leaves dataOutput holding
    do_store(M_WORD, 32'h8, 32'h1122_3344, 1'b0, 1'b0);
    chk("hold_after_store", dataOutput, 32'h0000_8000);
    chk("no_valid_on_store", {31'd0, dataValid}, 32'd0);

    // halfword store into upper lanes
    do_store(M_HALF, 32'h1A, 32'h1234_BEEF, 1'b0, 1'b0);
    do_load("lw_18", M_WORD, 32'h18, 1'b0, 1'b0, 1'b0, 32'h0, 32'hBEEF_0000);
    do_load("lh_1a", M_HALF, 32'h1A, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_BEEF);
    do_load("lhu_1a", M_HALF, 32'h1A, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_BEEF);
    do_load("lw_8", M_WORD, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1122_3344);
    do_load("lw_wrap_48", M_WORD, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1122_3344);

    // read-first fetch
    issue(M_NONE, M_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0,
          32'h0, "", 1'b1, 32'h0);
    do_idle(1'b0, 32'h13, 1'b1, 32'hDEAD_BEEF);

    // faults
    do_bad("lh_3_fault", M_HALF, M_NONE, 32'h3, 1'b0, 1'b0, 1'b0);
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_addr_first", faultAddress, 32'h3);
    do_bad("lw_7_fault", M_WORD, M_NONE, 32'h7, 1'b0, 1'b0, 1'b0);
    chk("fault_addr_sticky", faultAddress, 32'h3);
    do_bad("rw_both_fault", M_WORD, M_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    do_bad("both_flags_fault", M_WORD, M_NONE, 32'h4, 1'b1, 1'b1, 1'b0);
    chk("fault_addr_still", faultAddress, 32'h3);
    do_idle(1'b1, 32'h0, 1'b0, 32'h0);
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    chk("fault_addr_cleared", faultAddress, 32'h0);
    do_bad("clr_and_fault", M_HALF, M_NONE, 32'hD, 1'b0, 1'b0, 1'b1);
    chk("clr_fault_wins", {31'd0, fault}, 32'd1);
    chk("clr_fault_addr", faultAddress, 32'hD);
    do_bad("flag_byte_fault", M_NONE, M_BYTE, 32'h1, 1'b1, 1'b0, 1'b0);
    do_idle(1'b1, 32'h0, 1'b0, 32'h0);
    do_load("lw_0_untouched", M_WORD, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_load("lw_4_untouched", M_WORD, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_8000);

    // unaligned accesses
`ifdef UNALIGNED_EN
    do_load("lwl_9", M_WORD, 32'h9, 1'b0, 1'b1, 1'b0, 32'hAABB_CCDD, 32'h3344_CCDD);
    do_load("lwr_9", M_WORD, 32'h9, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD, 32'hAA11_2233);
    do_store(M_WORD, 32'h15, 32'hA1B2_C3D4, 1'b1, 1'b0);
    do_store(M_WORD, 32'h16, 32'h0102_0304, 1'b0, 1'b1);
    do_load("lw_14_swl_swr", M_WORD, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0304_A1B2);
    chk("no_fault_unaligned", {31'd0, fault}, 32'd0);
`else
    do_bad("lwl_1_fault", M_WORD, M_NONE, 32'h1, 1'b1, 1'b0, 1'b0);
    chk("lwl_fault_set", {31'd0, fault}, 32'd1);
    chk("lwl_fault_addr", faultAddress, 32'h1);
    do_bad("swl_15_fault", M_NONE, M_WORD, 32'h15, 1'b1, 1'b0, 1'b0);
    chk("swl_fault_addr", faultAddress, 32'h1);
    do_load("lw_14_untouched", M_WORD, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

    // drain and report
    @(negedge clk);
    #1;
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("fetch_queue_drained", 32'(pc_exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
